// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: one request at a time, serviced LATENCY cycles after acceptance.
// Optional build macro MEM_ALIGN_CHECK_EN rejects requests whose addr[1:0] is nonzero.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] rdata,
   output logic        resp_err,
   output logic        busy
);
   localparam int AW       = $clog2(DEPTH_WORDS);
   localparam bit ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              rd_q, wr_q;
   logic [AW+1:0]     addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              accept, fire;
   logic              a_rd, a_wr, a_err;
   logic [AW+1:0]     a_addr;
   logic [31:0]       a_wdata;
   logic [AW-1:0]     a_idx;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   // With zero latency the access happens on the accept edge, so it must use the live request.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      a_rd    = rd_q;
      a_wr    = wr_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      if (state == IDLE) begin
         a_rd    = mem_read;
         a_wr    = mem_write;
         a_addr  = addr[AW+1:0];
         a_wdata = wdata;
      end
      accept = req_valid && req_ready;
      fire   = (state == IDLE && accept && ZERO_LAT) || (state == WAIT && cnt == 4'd0);
`ifdef MEM_ALIGN_CHECK_EN
      a_err  = (a_rd == a_wr) || (a_addr[1:0] != 2'b00);
`else
      a_err  = (a_rd == a_wr);
`endif
      a_idx  = a_addr[AW+1:2];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         rdata      <= 32'd0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rd_q      <= mem_read;
                  wr_q      <= mem_write;
                  addr_q    <= addr[AW+1:0];
                  wdata_q   <= wdata;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (ZERO_LAT) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(LATENCY - 1);
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP: begin
               // rdata/resp_err are loaded on the entry edge; resp_valid follows one cycle later.
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
               end else if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  rdata      <= 32'd0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (fire) begin
            rdata    <= (a_rd && !a_err) ? mem[a_idx] : 32'd0;
            resp_err <= a_err;
         end
      end
   end

   // NOTE: the array has no reset; contents survive rst and only stores change them.
   always_ff @(posedge clk) begin
      if (fire && a_wr && !a_err) mem[a_idx] <= a_wdata;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 0), table vectors, reset corner cases, random traffic.
module tb_data_mem_responder;
   localparam int DEPTH = 1024;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2], req_ready [2], mem_read [2], mem_write [2];
   logic        resp_valid [2], resp_ready [2], resp_err [2], busy [2];
   logic [31:0] addr [2], wdata [2], rdata [2];

   int          checks   = 0;
   int          failures = 0;
   int          lat [2]  = '{2, 0};
   logic [31:0] mdl [2][DEPTH];

   typedef struct {
      int          d;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          hold;
   } vec_t;
   vec_t vecs [$];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .addr(addr[0]), .wdata(wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .rdata(rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .addr(addr[1]), .wdata(wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .rdata(rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference behaviour: word index wraps modulo DEPTH, bad opcodes (and misalignment if enabled) are errors.
   task automatic model_apply(input int d, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] w, output logic [31:0] erd, output bit eerr);
      int i;
      i    = int'((a >> 2) % DEPTH);
      eerr = (rd == wr) || (ALIGN && a[1:0] != 2'b00);
      erd  = 32'd0;
      if (!eerr) begin
         if (rd) erd = mdl[d][i];
         else    mdl[d][i] = w;
      end
   endtask

   task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] w, input logic [31:0] erd, input bit eerr, input int hold);
      int k;
      @(negedge clk);
      k = 0;
      while (!req_ready[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("d%0d req_ready before request", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1; mem_read[d] = rd; mem_write[d] = wr; addr[d] = a; wdata[d] = w;
      resp_ready[d] = 1'b0;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      mem_read[d]  = 1'($urandom); mem_write[d] = 1'($urandom);
      addr[d]      = $urandom;     wdata[d]     = $urandom;
      check($sformatf("d%0d busy after accept", d), 32'(busy[d]), 32'd1);
      check($sformatf("d%0d req_ready after accept", d), 32'(req_ready[d]), 32'd0);
      k = 0;
      while (!resp_valid[d] && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("d%0d response latency", d), 32'(k), 32'(lat[d] + 1));
      check($sformatf("d%0d rdata a=%h", d, a), rdata[d], erd);
      check($sformatf("d%0d resp_err a=%h", d, a), 32'(resp_err[d]), 32'(eerr));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check($sformatf("d%0d held resp_valid", d), 32'(resp_valid[d]), 32'd1);
         check($sformatf("d%0d held rdata", d), rdata[d], erd);
         check($sformatf("d%0d held req_ready", d), 32'(req_ready[d]), 32'd0);
      end
      @(negedge clk);
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      resp_ready[d] = 1'b0;
      check($sformatf("d%0d resp_valid after handshake", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("d%0d busy after handshake", d), 32'(busy[d]), 32'd0);
      check($sformatf("d%0d req_ready after handshake", d), 32'(req_ready[d]), 32'd1);
   endtask

   task automatic check_all_zero(input int d, input string tag);
      check($sformatf("%s d%0d req_ready", tag, d), 32'(req_ready[d]), 32'd0);
      check($sformatf("%s d%0d resp_valid", tag, d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("%s d%0d rdata", tag, d), rdata[d], 32'd0);
      check($sformatf("%s d%0d resp_err", tag, d), 32'(resp_err[d]), 32'd0);
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] erd, a, w;
      bit          eerr, rd, wr;
      int          op;

      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
         addr[d] = 32'd0; wdata[d] = 32'd0; resp_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check_all_zero(d, "in reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d req_ready after release", d), 32'(req_ready[d]), 32'd1);
         check($sformatf("d%0d busy after release", d), 32'(busy[d]), 32'd0);
         check($sformatf("d%0d resp_valid after release", d), 32'(resp_valid[d]), 32'd0);
      end

      vecs.push_back('{0, 1'b0, 1'b1, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0, 0});
      vecs.push_back('{0, 1'b1, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0, 5});
      vecs.push_back('{0, 1'b1, 1'b0, 32'h1040, 32'h0,        32'hDEADBEEF, 1'b0, 0});
      vecs.push_back('{0, 1'b1, 1'b1, 32'h40,   32'h11111111, 32'h0,        1'b1, 0});
      vecs.push_back('{0, 1'b0, 1'b0, 32'h40,   32'h22222222, 32'h0,        1'b1, 1});
      vecs.push_back('{0, 1'b1, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0, 0});
      vecs.push_back('{0, 1'b1, 1'b0, 32'h42,   32'h0, ALIGN ? 32'h0 : 32'hDEADBEEF, ALIGN, 0});
      vecs.push_back('{0, 1'b0, 1'b1, 32'h80,   32'h0,        32'h0,        1'b0, 0});
      vecs.push_back('{1, 1'b0, 1'b1, 32'h40,   32'hCAFEF00D, 32'h0,        1'b0, 0});
      vecs.push_back('{1, 1'b1, 1'b0, 32'h1040, 32'h0,        32'hCAFEF00D, 1'b0, 0});
      vecs.push_back('{1, 1'b1, 1'b1, 32'h40,   32'h33333333, 32'h0,        1'b1, 0});
      vecs.push_back('{1, 1'b1, 1'b0, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0, 2});

      foreach (vecs[i]) begin
         model_apply(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].w, erd, eerr);
         txn(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].w,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold);
      end

      // Reset in WAIT drops an in-flight store to 0x80.
      @(negedge clk);
      req_valid[0] = 1'b1; mem_read[0] = 1'b0; mem_write[0] = 1'b1;
      addr[0] = 32'h80; wdata[0] = 32'h12345678;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      check("busy in WAIT", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero(0, "async reset in WAIT");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("req_ready after mid-txn reset", 32'(req_ready[0]), 32'd1);
      txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 0);

      // Fill words 0..7 of each array so random loads read known data.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            w = $urandom;
            model_apply(d, 1'b0, 1'b1, 32'(i * 4), w, erd, eerr);
            txn(d, 1'b0, 1'b1, 32'(i * 4), w, erd, eerr, 0);
         end
      end

      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 7);
         rd = (op == 0) || (op >= 2 && op <= 4);
         wr = (op == 0) || (op >= 5);
         a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         w  = $urandom;
         model_apply(n % 2, rd, wr, a, w, erd, eerr);
         txn(n % 2, rd, wr, a, w, erd, eerr, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the MIPS core's data port: accepts one read or write request at a time over a valid/ready handshake, services it from an internal word-addressed array after a programmable number of wait states, and returns a response (read data or write acknowledge) over a second valid/ready handshake. It sits between the core's load/store interface (MemRead/MemWrite, address, write data) and the on-chip data RAM. It lets the multi-cycle and pipelined cores be exercised against a memory that is not zero-latency.

## Interface
- DEPTH_WORDS, 1024: array size in 32-bit words; power of two.
- LATENCY, 2: wait-state cycles between request acceptance and response; 0..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- mem_read  in  1  request is a load; sampled on acceptance.
- mem_write  in  1  request is a store; sampled on acceptance.
- addr  in  32  byte address; sampled on acceptance.
- wdata  in  32  store data; sampled on acceptance.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- rdata  out  32  load data; 0 for store responses and errors.
- resp_err  out  1  request rejected; no array access performed.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch mem_read, mem_write, addr, wdata. Go to WAIT if LATENCY>0 (load counter with LATENCY-1), else go directly to RESP.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
- Access takes effect on the edge entering RESP:
  - Load: rdata <= mem[idx].
  - Store: mem[idx] <= wdata; rdata <= 0.
- idx = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Error cases, each giving resp_err=1, rdata=0, and no array read or write:
  - mem_read&&mem_write both set.
  - Neither set.
- RESP: resp_valid=1. rdata and resp_err hold stable until resp_valid&&resp_ready, then return to IDLE. The next request cannot be accepted in that same cycle.
- Outputs are registered; none depend combinationally on req_valid or resp_ready.
- Reset (any time, including mid-transaction) forces IDLE and clears all outputs. An in-flight store whose access edge has not occurred is dropped. Array contents are not reset.
- Reset values: req_ready=0 while rst is high and 1 in the first cycle after release; resp_valid=0, rdata=0, resp_err=0, busy=0.

## Timing
- Request accepted at edge N: resp_valid rises after edge N+LATENCY+1 and stays high until the handshake edge.
- Minimum request-to-request spacing is LATENCY+3 cycles: accept, LATENCY waits, RESP, IDLE.
- A store followed by a load to the same address returns the new data (no hazard, single outstanding request).
- req_ready=0 in WAIT/RESP. Requests presented then are not sampled; the requester must hold them.

## Configuration
- MEM_ALIGN_CHECK_EN:
  - Defined: a request with addr[1:0]!=0 is an error (resp_err=1, rdata=0, array untouched), with normal latency.
  - Undefined: addr[1:0] is ignored and misaligned accesses hit the containing word.
  - Error cases from the Operation section apply in both builds.

## Test plan
- Reset release, LATENCY=2: req_ready=1, busy=0, resp_valid=0. Store 0xDEADBEEF to 0x40, accepted at edge N → resp_valid after edge N+3, rdata=0, resp_err=0.
- Load 0x40 after the store → rdata=0xDEADBEEF. Load 0x40+4*DEPTH_WORDS → same data (wrap).
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and rdata stay stable, req_ready=0. Then pulse resp_ready → IDLE next cycle.
- mem_read=mem_write=1 at addr 0x40 → resp_err=1, rdata=0. A following load of 0x40 still returns 0xDEADBEEF.
- With MEM_ALIGN_CHECK_EN, load 0x42 → resp_err=1. Without it → rdata=0xDEADBEEF.
- Assert rst during WAIT of a store of 0x12345678 to 0x80 (previously 0) → all outputs 0 immediately. Subsequent load of 0x80 → 0. Repeat with LATENCY=0 → resp_valid one cycle after acceptance.
